// File: rtl/m6809_pkg.sv
// Shared definitions for the MC6809-subset core: opcodes, CC bit positions, FSM states, ALU functions.
package m6809_pkg;

    localparam logic [15:0] DEF_RESET_VEC = 16'hFFFE;
    localparam logic [7:0]  CC_RESET      = 8'h50;

    localparam logic [7:0] OP_NOP      = 8'h12;
    localparam logic [7:0] OP_INCA     = 8'h4C;
    localparam logic [7:0] OP_DECA     = 8'h4A;
    localparam logic [7:0] OP_CLRA     = 8'h4F;
    localparam logic [7:0] OP_LDA_IMM  = 8'h86;
    localparam logic [7:0] OP_LDB_IMM  = 8'hC6;
    localparam logic [7:0] OP_ADDA_IMM = 8'h8B;
    localparam logic [7:0] OP_ADDB_IMM = 8'hCB;
    localparam logic [7:0] OP_LDA_EXT  = 8'hB6;
    localparam logic [7:0] OP_LDB_EXT  = 8'hF6;
    localparam logic [7:0] OP_STA_EXT  = 8'hB7;
    localparam logic [7:0] OP_STB_EXT  = 8'hF7;
    localparam logic [7:0] OP_JMP_EXT  = 8'h7E;
    localparam logic [7:0] OP_BRA      = 8'h20;
    localparam logic [7:0] OP_BEQ      = 8'h27;
    localparam logic [7:0] OP_BNE      = 8'h26;

    localparam int CC_E = 7;
    localparam int CC_F = 6;
    localparam int CC_H = 5;
    localparam int CC_I = 4;
    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_V = 1;
    localparam int CC_C = 0;

    typedef enum logic [2:0] {VEC_HI, VEC_LO, FETCH, OP1, OP2, MEM} state_t;
    typedef enum logic [2:0] {ALU_PASS, ALU_ADD, ALU_INC, ALU_DEC, ALU_CLR} alu_fn_t;

    // Opcodes that need at least one operand byte after the fetch.
    function automatic logic has_operand(input logic [7:0] op);
        case (op)
            OP_LDA_IMM, OP_LDB_IMM, OP_ADDA_IMM, OP_ADDB_IMM,
            OP_LDA_EXT, OP_LDB_EXT, OP_STA_EXT, OP_STB_EXT,
            OP_JMP_EXT, OP_BRA, OP_BEQ, OP_BNE: has_operand = 1'b1;
            default:                            has_operand = 1'b0;
        endcase
    endfunction

    function automatic logic is_ext(input logic [7:0] op);
        case (op)
            OP_LDA_EXT, OP_LDB_EXT, OP_STA_EXT, OP_STB_EXT, OP_JMP_EXT: is_ext = 1'b1;
            default:                                                   is_ext = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        is_store = (op == OP_STA_EXT) || (op == OP_STB_EXT);
    endfunction

endpackage

// File: rtl/m6809_alu.sv
// Combinational 8-bit ALU: pass/add/inc/dec/clr with 6809 H,N,Z,V,C; untouched flags pass through from cc_in.
module m6809_alu
    import m6809_pkg::*;
(
    input  logic [2:0] fn,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] cc_in,
    output logic [7:0] res,
    output logic       h,
    output logic       n,
    output logic       z,
    output logic       v,
    output logic       c
);

    logic [8:0] sum;
    logic [4:0] nib;

    assign sum = {1'b0, a} + {1'b0, b};
    assign nib = {1'b0, a[3:0]} + {1'b0, b[3:0]};

    always_comb begin
        res = b;
        h   = cc_in[CC_H];
        v   = 1'b0;
        c   = cc_in[CC_C];
        case (fn)
            ALU_ADD: begin
                res = sum[7:0];
                h   = nib[4];
                c   = sum[8];
                v   = (a[7] == b[7]) && (sum[7] != a[7]);
            end
            ALU_INC: begin
                res = a + 8'd1;
                v   = (a == 8'h7F);
            end
            ALU_DEC: begin
                res = a - 8'd1;
                v   = (a == 8'h80);
            end
            ALU_CLR: begin
                res = 8'h00;
                c   = 1'b0;
            end
            default: ;
        endcase
        n = res[7];
        z = (res == 8'h00);
    end

endmodule

// File: rtl/m6809_cpu_core.sv
// Cycle-based MC6809-subset core, one bus cycle per clk, boots from a big-endian reset vector.
// Build option: define M6809_HALT_EN to add the active-low halt_b input, sampled in FETCH.
module m6809_cpu_core
    import m6809_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = DEF_RESET_VEC
) (
    input  logic        clk,
    input  logic        reset_b,
`ifdef M6809_HALT_EN
    input  logic        halt_b,
`endif
    output logic [15:0] addr,
    input  logic [7:0]  din,
    output logic [7:0]  data_out,
    output logic        data_rw_n
);

    state_t      state, state_nxt;
    logic [15:0] pc, ea, pc_inc;
    logic [7:0]  a, b, cc, op;
    logic        halt;

    alu_fn_t     alu_fn;
    logic [7:0]  alu_a, alu_b, alu_res, cc_nxt;
    logic        f_h, f_n, f_z, f_v, f_c;

`ifdef M6809_HALT_EN
    assign halt = ~halt_b;
`else
    assign halt = 1'b0;
`endif

    assign pc_inc = pc + 16'd1;
    assign cc_nxt = {cc[CC_E], cc[CC_F], f_h, cc[CC_I], f_n, f_z, f_v, f_c};

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= VEC_HI;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            VEC_HI: state_nxt = VEC_LO;
            VEC_LO: state_nxt = FETCH;
            FETCH:  if (!halt && has_operand(din)) state_nxt = OP1;
            OP1:    state_nxt = is_ext(op) ? OP2 : FETCH;
            OP2:    state_nxt = (op == OP_JMP_EXT) ? FETCH : MEM;
            MEM:    state_nxt = FETCH;
            default: state_nxt = VEC_HI;
        endcase
    end

    // Bus outputs decode from registered state only, so reset forces a read cycle at once.
    always_comb begin
        addr      = pc;
        data_rw_n = 1'b1;
        data_out  = 8'h00;
        case (state)
            VEC_HI: addr = RESET_VEC;
            VEC_LO: addr = RESET_VEC + 16'd1;
            MEM: begin
                addr = ea;
                if (is_store(op)) begin
                    data_rw_n = 1'b0;
                    data_out  = (op == OP_STB_EXT) ? b : a;
                end
            end
            default: ;
        endcase
    end

    // Inherent ops execute on the fetch edge straight from din, before op is latched.
    always_comb begin
        alu_fn = ALU_PASS;
        alu_a  = a;
        alu_b  = din;
        case (state)
            FETCH: case (din)
                OP_INCA: alu_fn = ALU_INC;
                OP_DECA: alu_fn = ALU_DEC;
                OP_CLRA: alu_fn = ALU_CLR;
                default: ;
            endcase
            OP1: case (op)
                OP_ADDA_IMM: alu_fn = ALU_ADD;
                OP_ADDB_IMM: begin alu_fn = ALU_ADD; alu_a = b; end
                default: ;
            endcase
            MEM: case (op)
                OP_STA_EXT: alu_b = a;
                OP_STB_EXT: alu_b = b;
                default: ;
            endcase
            default: ;
        endcase
    end

    m6809_alu u_alu (
        .fn    (alu_fn),
        .a     (alu_a),
        .b     (alu_b),
        .cc_in (cc),
        .res   (alu_res),
        .h     (f_h),
        .n     (f_n),
        .z     (f_z),
        .v     (f_v),
        .c     (f_c)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pc <= 16'h0000;
            ea <= 16'h0000;
            a  <= 8'h00;
            b  <= 8'h00;
            op <= 8'h00;
            cc <= CC_RESET;
        end else begin
            case (state)
                VEC_HI: pc[15:8] <= din;
                VEC_LO: pc[7:0]  <= din;
                FETCH: if (!halt) begin
                    op <= din;
                    pc <= pc_inc;
                    if (din == OP_INCA || din == OP_DECA || din == OP_CLRA) begin
                        a  <= alu_res;
                        cc <= cc_nxt;
                    end
                end
                OP1: begin
                    pc <= pc_inc;
                    case (op)
                        OP_LDA_IMM, OP_ADDA_IMM: begin a <= alu_res; cc <= cc_nxt; end
                        OP_LDB_IMM, OP_ADDB_IMM: begin b <= alu_res; cc <= cc_nxt; end
                        OP_BRA: pc <= pc_inc + {{8{din[7]}}, din};
                        OP_BEQ: if (cc[CC_Z])  pc <= pc_inc + {{8{din[7]}}, din};
                        OP_BNE: if (!cc[CC_Z]) pc <= pc_inc + {{8{din[7]}}, din};
                        default: ea[15:8] <= din;
                    endcase
                end
                OP2: begin
                    ea[7:0] <= din;
                    if (op == OP_JMP_EXT) pc <= {ea[15:8], din};
                    else                  pc <= pc_inc;
                end
                MEM: case (op)
                    OP_LDA_EXT: begin a <= alu_res; cc <= cc_nxt; end
                    OP_LDB_EXT: begin b <= alu_res; cc <= cc_nxt; end
                    OP_STA_EXT, OP_STB_EXT: cc <= cc_nxt;
                    default: ;
                endcase
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m6809_cpu_core.sv
// Directed bench for m6809_cpu_core with a behavioural ROM ($FF00-$FFFF) and RAM ($0000-$00FF).
module tb_m6809_cpu_core;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
`ifdef M6809_HALT_EN
    logic        halt_b = 1'b1;
`endif
    logic [15:0] addr;
    logic [7:0]  din, data_out;
    logic        data_rw_n;

    logic [7:0] rom [256];
    logic [7:0] ram [256] = '{default: 8'h00};
    int checks = 0, failures = 0, wr_cnt = 0, dec_cnt = 0, wr_base;

    // Program image for $FF00-$FF25; $FF30-$FF35 is placed separately.
    logic [7:0] prog [38] = '{
        8'h86, 8'h80, 8'hB7, 8'h00, 8'h10, 8'h8B, 8'h80, 8'hB7, 8'h00, 8'h11,
        8'h86, 8'h03, 8'h4A, 8'h26, 8'hFD, 8'hB7, 8'h00, 8'h12, 8'h4C, 8'hC6,
        8'h7F, 8'hCB, 8'h01, 8'hF7, 8'h00, 8'h13, 8'hF6, 8'h00, 8'h10, 8'h27,
        8'h02, 8'h4F, 8'h27, 8'h01, 8'h4C, 8'h7E, 8'hFF, 8'h30};

    always #5 clk = ~clk;

    m6809_cpu_core #(.RESET_VEC(16'hFFFE)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
`ifdef M6809_HALT_EN
        .halt_b    (halt_b),
`endif
        .addr      (addr),
        .din       (din),
        .data_out  (data_out),
        .data_rw_n (data_rw_n)
    );

    always_comb begin
        din = 8'h00;
        if (addr[15:8] == 8'hFF)      din = rom[addr[7:0]];
        else if (addr[15:8] == 8'h00) din = ram[addr[7:0]];
    end

    always @(posedge clk) begin
        if (!data_rw_n && addr[15:8] == 8'h00) begin
            ram[addr[7:0]] <= data_out;
            wr_cnt         <= wr_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (reset_b && addr == 16'hFF0C) dec_cnt <= dec_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_addr(input logic [15:0] target, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (addr !== target && n < 400);
        chk(tag, addr, target);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h01;
        for (int i = 0; i < 38; i++) rom[i] = prog[i];
        rom[8'h30] = 8'h01; rom[8'h31] = 8'hB7; rom[8'h32] = 8'h00;
        rom[8'h33] = 8'h14; rom[8'h34] = 8'h20; rom[8'h35] = 8'hFE;
        rom[8'hFE] = 8'hFF; rom[8'hFF] = 8'h00;

        // Reset state and vector fetch
        repeat (2) @(negedge clk);
        chk("rst_addr", addr, 16'hFFFE);
        chk("rst_rw", {15'd0, data_rw_n}, 16'd1);
        chk("rst_dout", {8'd0, data_out}, 16'h0000);
        reset_b = 1'b1;
        #1 chk("vec_hi", addr, 16'hFFFE);
        @(negedge clk) chk("vec_lo", addr, 16'hFFFF);
        chk("vec_lo_rw", {15'd0, data_rw_n}, 16'd1);
        @(negedge clk) chk("first_fetch", addr, 16'hFF00);
        chk("fetch_rw", {15'd0, data_rw_n}, 16'd1);

        // STA write cycle, ADD flags, loop, branches
        wait_addr(16'h0010, "sta_addr");
        chk("sta_rw", {15'd0, data_rw_n}, 16'd0);
        chk("sta_data", {8'd0, data_out}, 16'h0080);
        @(negedge clk) chk("sta_one_cycle", {15'd0, data_rw_n}, 16'd1);
        wait_addr(16'hFF07, "reach_ff07");
        chk("adda_cc", {8'd0, dut.cc}, 16'h0057);
        wait_addr(16'hFF17, "reach_ff17");
        chk("addb_cc", {8'd0, dut.cc}, 16'h007A);
        wait_addr(16'hFF34, "reach_bra");
        @(negedge clk) chk("bra_off0", addr, 16'hFF35);
        @(negedge clk) chk("bra_op1", addr, 16'hFF34);
        @(negedge clk) chk("bra_off1", addr, 16'hFF35);
        @(negedge clk) chk("bra_op2", addr, 16'hFF34);
        chk("ram10", {8'd0, ram[8'h10]}, 16'h0080);
        chk("ram11", {8'd0, ram[8'h11]}, 16'h0000);
        chk("ram12", {8'd0, ram[8'h12]}, 16'h0000);
        chk("ram13", {8'd0, ram[8'h13]}, 16'h0080);
        chk("ram14_beq_skip", {8'd0, ram[8'h14]}, 16'h0000);
        chk("write_count", wr_cnt[15:0], 16'd5);
        chk("loop_count", dec_cnt[15:0], 16'd3);

        // Reset asserted in the STA operand cycle before the write
        do_reset();
        wr_base = wr_cnt;
        wait_addr(16'hFF04, "reach_sta_op2");
        reset_b = 1'b0;
        #1 chk("abort_addr", addr, 16'hFFFE);
        chk("abort_rw", {15'd0, data_rw_n}, 16'd1);
        @(negedge clk) chk("abort_no_write", wr_cnt[15:0], wr_base[15:0]);
        reset_b = 1'b1;
        #1 chk("restart_vec_hi", addr, 16'hFFFE);
        @(negedge clk) chk("restart_vec_lo", addr, 16'hFFFF);
        @(negedge clk) chk("restart_fetch", addr, 16'hFF00);

        // Reset asserted during the write cycle itself
        wr_base = wr_cnt;
        wait_addr(16'h0010, "reach_write");
        chk("write_rw", {15'd0, data_rw_n}, 16'd0);
        reset_b = 1'b0;
        #1 chk("wr_abort_rw", {15'd0, data_rw_n}, 16'd1);
        @(negedge clk) chk("wr_abort_no_write", wr_cnt[15:0], wr_base[15:0]);
        reset_b = 1'b1;

`ifdef M6809_HALT_EN
        // Halt requested mid LDB ext: instruction completes, then fetch holds
        wait_addr(16'hFF1B, "reach_ldb_op1");
        halt_b = 1'b0;
        @(negedge clk) chk("halt_op2", addr, 16'hFF1C);
        @(negedge clk) chk("halt_mem", addr, 16'h0010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) chk("halt_hold", addr, 16'hFF1D);
            chk("halt_rw", {15'd0, data_rw_n}, 16'd1);
        end
        halt_b = 1'b1;
        @(negedge clk) chk("halt_resume", addr, 16'hFF1E);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
